mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//   Multi-cycle multiply/divide controller for the MIPS HI/LO unit. Sequences an
//   iterative shift-add multiplier / restoring divider for R-type funct codes
//   mult/multu/div/divu and owns the HI/LO registers. Sits beside the single-cycle
//   ALU in EX; busy stalls the front of the pipeline while an operation runs.
//   Also services mthi/mtlo writes.
// PARAMETERS
//   WIDTH   32   operand width; one iteration per bit, so CALC lasts WIDTH cycles
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request valid this cycle
//   funct         in   6      R-type funct: 18 mult, 19 multu, 1A div, 1B divu, 11 mthi, 13 mtlo (hex)
//   a             in   WIDTH  rs value (multiplicand / dividend / mthi-mtlo data)
//   b             in   WIDTH  rt value (multiplier / divisor)
//   busy          out  1      operation in progress; start is ignored while high
//   done          out  1      one-cycle pulse: hi/lo hold the new result this cycle
//   div_by_zero   out  1      one-cycle pulse with done when a div/divu had b==0
//   hi            out  WIDTH  HI register
//   lo            out  WIDTH  LO register
// BEHAVIOUR
//   Clock/reset: one clock clk; rst synchronous active-high.
//   Reset: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
//     rst mid-operation aborts: no done pulse, partial result discarded.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start && funct in {18,19,1A,1B} latches a, b, funct; go to CALC, busy=1
//     next cycle. Signed ops (18, 1A) latch |a|, |b| plus the sign flags.
//     start && funct==11: hi<=a next edge. funct==13: lo<=a. Neither sets busy
//     or done. Any other funct: ignored, no state change.
//   CALC: exactly WIDTH cycles, down-counter WIDTH-1..0.
//     Multiply: 2*WIDTH-bit shift-add on magnitudes.
//     Divide: restoring, one quotient bit per cycle, MSB first.
//   FIX: one cycle. Signed mult: negate the 2*WIDTH product if the signs differ.
//     Signed div: negate the quotient if the signs differ. Remainder takes the
//     sign of the dividend. Write hi/lo at end of FIX.
//   Result mapping: mult hi:lo = product; div lo=quotient, hi=remainder.
//   Timing: start accepted at edge T -> busy high T+1..T+WIDTH+1.
//     At T+WIDTH+2: busy=0, done=1, hi/lo valid.
//     start in the done cycle is accepted normally (back-to-back ops).
//   Divide by zero: still full latency; lo=all ones, hi=a (raw, unsigned view),
//     div_by_zero=1 with done. Same for signed div.
//   Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no flag).
//   While busy: start of any funct, including mthi/mtlo, is ignored.
//     hi/lo hold their old values until the FIX write.
//   All arithmetic is modulo 2^WIDTH per register; no exceptions raised.
// TESTING
//   multu a=FFFFFFFF b=FFFFFFFF at T -> done at T+34, hi=FFFFFFFE lo=00000001
//   mult a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1, div_by_zero=0
//   div a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF
//     then div a=80000000 b=FFFFFFFF -> lo=80000000 hi=0
//   divu a=0000000A b=0 -> at T+34 done=1 div_by_zero=1, lo=FFFFFFFF hi=0000000A
//   mthi a=12345678 in IDLE -> hi=12345678 next cycle, busy/done stay 0
//     mtlo or multu during busy -> ignored, original result completes unchanged
//   start multu at T, rst at T+10 -> busy=0, hi=lo=0 at T+11, no done pulse
//     start at T+12 runs normally

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the MIPS HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with the sign applied in a final FIX cycle.
module mdu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;
   logic             op_div;
   logic             neg_res;
   logic             neg_rem;
   logic             zero_div;
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;

   logic             is_muldiv;
   logic             sign_op;
   logic             accept;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                  (funct == F_DIV)  || (funct == F_DIVU);
      sign_op   = (funct == F_MULT) || (funct == F_DIV);
      accept    = start && (state == IDLE) && is_muldiv;
      mag_a     = (sign_op && a[WIDTH-1]) ? -a : a;
      mag_b     = (sign_op && b[WIDTH-1]) ? -b : b;
   end

   // acc:q doubles as the 2*WIDTH product during multiply and as remainder:dividend during divide.
   always_comb begin
      mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      div_shift = {acc, q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      div_diff  = div_shift[WIDTH-1:0] - opb;
      prod      = {acc, q};
      prod_fix  = neg_res ? -prod : prod;
      quot_fix  = neg_res ? -q : q;
      rem_fix   = neg_rem ? -acc : acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (count == '0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         op_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         zero_div    <= 1'b0;
         a_raw       <= '0;
         opb         <= '0;
         acc         <= '0;
         q           <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_muldiv) begin
                     count    <= CW'(WIDTH - 1);
                     op_div   <= funct[1];
                     neg_res  <= sign_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem  <= sign_op && a[WIDTH-1];
                     zero_div <= (b == '0);
                     a_raw    <= a;
                     acc      <= '0;
                     opb      <= funct[1] ? mag_b : mag_a;
                     q        <= funct[1] ? mag_a : mag_b;
                  end else if (funct == F_MTHI) begin
                     hi <= a;
                  end else if (funct == F_MTLO) begin
                     lo <= a;
                  end
               end
            end
            CALC: begin
               count <= count - 1'b1;
               if (op_div) begin
                  acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  q   <= {q[WIDTH-2:0], div_ge};
               end else begin
                  acc <= mul_sum[WIDTH:1];
                  q   <= {mul_sum[0], q[WIDTH-1:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               // A zero divisor reports the raw dividend, not its magnitude.
               if (op_div) begin
                  if (zero_div) begin
                     hi          <= a_raw;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quot_fix;
                  end
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: a 64-bit arithmetic reference model predicts each
// HI/LO result and its completion cycle; a negedge monitor compares whenever done pulses.
module tb_mdu_sequencer;

   localparam int WIDTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic [31:0] due;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   busy_end = 0;

   mdu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .funct       (funct),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Reference result computed with wide plain arithmetic rather than iteration.
   function automatic exp_t refModel(input logic [5:0] f, input logic [31:0] x,
                                     input logic [31:0] y, input int due);
      exp_t e;
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic signed [63:0] sr;
      logic [63:0] up;
      e.due = 32'(due);
      e.dz  = 1'b0;
      e.hi  = '0;
      e.lo  = '0;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      case (f)
         6'h18: begin
            sr = sx * sy;
            {e.hi, e.lo} = sr;
         end
         6'h19: begin
            up = {32'b0, x} * {32'b0, y};
            {e.hi, e.lo} = up;
         end
         6'h1A, 6'h1B: begin
            if (y == 32'b0) begin
               e.lo = '1;
               e.hi = x;
               e.dz = 1'b1;
            end else if (f == 6'h1A) begin
               sr = sx / sy;
               e.lo = sr[31:0];
               sr = sx % sy;
               e.hi = sr[31:0];
            end else begin
               e.lo = x / y;
               e.hi = x % y;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Call just after a negedge; returns #1 after the following posedge.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      logic idle;
      logic muldiv;
      idle   = (cyc >= busy_end);
      muldiv = (f == 6'h18) || (f == 6'h19) || (f == 6'h1A) || (f == 6'h1B);
      start = 1'b1;
      funct = f;
      a     = x;
      b     = y;
      if (idle && muldiv) begin
         busy_end = cyc + WIDTH + 2;
         exp_q.push_back(refModel(f, x, y, busy_end));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (idle && muldiv) checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
      if (idle && f == 6'h11) begin
         checkOutput("mthi_hi", hi, x);
         checkOutput("mthi_busy", {31'b0, busy}, 32'd0);
         checkOutput("mthi_done", {31'b0, done}, 32'd0);
      end
      if (idle && f == 6'h13) begin
         checkOutput("mtlo_lo", lo, x);
         checkOutput("mtlo_busy", {31'b0, busy}, 32'd0);
      end
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("[TB] FAIL done_timeout: got no done expected done within 200 cycles");
         exp_q.delete();
         busy_end = 0;
      end
   endtask

   task automatic waitDoneCycle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (cyc < busy_end && guard < 200) begin
         @(negedge clk);
         guard++;
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("[TB] FAIL spurious_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("hi", hi, e.hi);
               checkOutput("lo", lo, e.lo);
               checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
               checkOutput("done_cycle", 32'(cyc), e.due);
               checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
            end
         end else if (div_by_zero) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL stray_div_by_zero: got 1 expected 0 at cycle %0d", cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 1 ms");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] fsel [12];
      fsel = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h18, 6'h19, 6'h1A, 6'h1B,
               6'h11, 6'h13, 6'h00, 6'h2A};
      rst   = 1'b1;
      start = 1'b0;
      funct = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_dz", {31'b0, div_by_zero}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);

      @(negedge clk);
      applyStimulus(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitIdle();
      applyStimulus(6'h18, 32'hFFFF_FFFD, 32'h0000_0005);
      waitIdle();
      applyStimulus(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002);
      waitDoneCycle();
      applyStimulus(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle();
      applyStimulus(6'h1B, 32'h0000_000A, 32'h0000_0000);
      waitIdle();

      applyStimulus(6'h11, 32'h1234_5678, 32'h0);
      @(negedge clk);
      applyStimulus(6'h13, 32'hCAFE_F00D, 32'h0);
      @(negedge clk);
      applyStimulus(6'h19, 32'h0000_0003, 32'h0000_0004);
      repeat (5) @(negedge clk);
      applyStimulus(6'h13, 32'h0000_DEAD, 32'h0);
      @(negedge clk);
      applyStimulus(6'h19, 32'h0000_0007, 32'h0000_0007);
      @(negedge clk);
      checkOutput("lo_hold_while_busy", lo, 32'hCAFE_F00D);
      checkOutput("busy_mid_op", {31'b0, busy}, 32'd1);
      waitIdle();

      applyStimulus(6'h19, 32'h0001_2345, 32'h0000_0777);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      busy_end = 0;
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_hi", hi, 32'd0);
      checkOutput("abort_lo", lo, 32'd0);
      repeat (WIDTH + 4) @(negedge clk);
      applyStimulus(6'h19, 32'h0000_0006, 32'h0000_0007);
      waitIdle();

      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(fsel[$urandom_range(0, 11)], pickOperand(), pickOperand());
         @(negedge clk);
      end
      waitIdle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
